sequencer: RTL and testbench
============================

// Module: sequencer
// PURPOSE
// Microsequencer directly upstream of the control-signal decoder. It walks each instruction
// through its sequence of 8-bit state codes, latches the operand fields, and drives
// state/operand_1/operand_2 into the decoder. It also stalls on the IO-port handshake and
// parks the CPU on HALT until resume.
// PARAMETERS
// IO_TIMEOUT  255  max cycles spent in IO_WAIT before giving up (1..2**TO_W-1)
// TO_W        8    width of IO timeout counter
// PORTS
// clk        in   1  system clock, rising edge
// reset_n    in   1  asynchronous active-low reset
// run_en     in   1  1 = execute; 0 = park in IDLE at next instruction boundary
// resume     in   1  single-cycle pulse, leaves HALT
// ir         in   8  instruction register contents {op[7:6], f1[5:3], f2[2:0]}
// io_ack     in   1  IO port accepted the word driven under c_go
// state      out  8  current state code, registered, feeds decoder
// operand_1  out  3  ir[5:3] latched in DECODE
// operand_2  out  3  ir[2:0] latched in DECODE
// instr_done out  1  1-cycle pulse in last state of every instruction (incl. NOP)
// halted     out  1  high while state==HALT
// io_err     out  1  sticky: IO timeout occurred; cleared only by reset
// BEHAVIOUR
// Codes: IDLE 00, FETCH_PC 01, FETCH_INST 02, DECODE 03, ALU_EXEC 10, ALU_OUT 11, MOVE_REG 20,
//  SET_MAR 30, LOAD_ADDR 31, SET_REG 32, SET_MEM 33, FETCH_SP 40, STACK_REG 41, INC_SP 42,
//  JUMP 50, TMP_JUMP 51, STORE_PC 52, RET 53, MOUT_STORE 60, ROUT_STORE 61, IO_WAIT 62, HALT FF.
// Reset: state=IDLE, operands=0, step=0, instr_done=0, halted=0, io_err=0, timeout cnt=0.
// IDLE -> FETCH_PC when run_en=1. One state per clock, no other stalls.
// Boundary: after the last execute state, go to FETCH_PC if run_en=1, else IDLE.
// FETCH_PC -> FETCH_INST -> DECODE. In DECODE, sample ir, latch operands, select sequence.
// Execute sequences after DECODE (op,f1):
//  00,xxx ALU: ALU_EXEC, ALU_OUT | 01,xxx MOV: MOVE_REG
//  10,000 LD: FETCH_PC, LOAD_ADDR, SET_REG | 10,001 ST: FETCH_PC, LOAD_ADDR, SET_MEM
//  10,010 LDI: FETCH_PC, SET_REG | 10,011 LD dyn: SET_MAR, SET_REG
//  10,100 PUSH: FETCH_SP, STACK_REG | 10,101 POP: INC_SP, FETCH_SP, SET_REG
//  11,000 Jcc: FETCH_PC, JUMP | 11,001 CALL: FETCH_PC, FETCH_SP, STORE_PC, TMP_JUMP
//  11,010 RET: INC_SP, FETCH_SP, RET | 11,011 MOUT: FETCH_PC, LOAD_ADDR, MOUT_STORE
//  11,100 ROUT: ROUT_STORE | 11,111 HALT: HALT | other codes: NOP.
// NOP: DECODE asserts instr_done and goes straight to the boundary.
// Jcc condition is evaluated by the decoder only. The sequence is identical taken or not.
// Sequencing uses an internal step counter. A repeated code (e.g. FETCH_PC) mid-sequence must
//  not be confused with fetch.
// IO: in MOUT_STORE/ROUT_STORE, if io_ack=1 that cycle -> done. Otherwise -> IO_WAIT
//  (operands held) and count cycles. Leave IO_WAIT on io_ack=1.
//  After IO_TIMEOUT cycles in IO_WAIT without ack: set io_err and leave anyway.
//  instr_done pulses in the leaving cycle.
// HALT: halted=1, instr_done pulses on entry. Hold until resume=1, then -> FETCH_PC.
//  A resume while not halted is ignored.
// run_en=0 mid-instruction does not abort it; it only takes effect at the boundary.
// Reset asserted mid-instruction: immediate IDLE, no partial sequence resumes.
// operand_1/2 are stable from the cycle after DECODE until the next DECODE.
// TESTING
// reset_n low, run_en=1 -> state=00; after release: 01,02,03 on successive clocks.
// ir=8'h1A (ALU) -> 03,10,11,01; operand_1=3, operand_2=2; instr_done high only in 11.
// ir=8'hA3 (PUSH r3) -> 03,40,41,01; ir=8'hAB (POP r3) -> 03,42,40,32,01.
// ir=8'hE0 (ROUT), io_ack low, IO_TIMEOUT=4 -> 61, 62 x4, 01; io_err=1 and stays 1.
// ir=8'hF8 (HALT) -> FF held 10 cycles, halted=1; resume pulse -> 01 next clock.
// run_en dropped during 31 of LD -> 32 then 00. Reset during 62 -> 00, io_err=0, operands=0.

Source files
------------

// File: rtl/sequencer.sv
// ---------------------------------------------------------------------------
// sequencer
// Microsequencer that sits directly upstream of the control-signal decoder.
// It steps each instruction through its list of 8-bit state codes, latches the
// operand fields of the instruction register, stalls on the IO handshake, and
// parks the CPU in HALT until it receives a resume pulse.
//
// Parameters
//   IO_TIMEOUT  maximum number of cycles spent in IO_WAIT without an ack
//   TO_W        width of the IO timeout counter
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   run_en      1 = execute, 0 = park in IDLE at the next instruction boundary
//   resume      single-cycle pulse that leaves HALT
//   ir          instruction register {op[7:6], f1[5:3], f2[2:0]}
//   io_ack      IO port accepted the word offered in a store state
//   state       current state code (registered), drives the decoder
//   operand_1   ir[5:3], latched in DECODE
//   operand_2   ir[2:0], latched in DECODE
//   instr_done  one-cycle pulse in the last state of every instruction
//   halted      high while the state is HALT
//   io_err      sticky IO timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module sequencer #(
  parameter int IO_TIMEOUT = 255,
  parameter int TO_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run_en,
  input  logic       resume,
  input  logic [7:0] ir,
  input  logic       io_ack,
  output logic [7:0] state,
  output logic [2:0] operand_1,
  output logic [2:0] operand_2,
  output logic       instr_done,
  output logic       halted,
  output logic       io_err
);

  // State codes seen by the decoder
  localparam logic [7:0] IDLE       = 8'h00;
  localparam logic [7:0] FETCH_PC   = 8'h01;
  localparam logic [7:0] FETCH_INST = 8'h02;
  localparam logic [7:0] DECODE     = 8'h03;
  localparam logic [7:0] ALU_EXEC   = 8'h10;
  localparam logic [7:0] ALU_OUT    = 8'h11;
  localparam logic [7:0] MOVE_REG   = 8'h20;
  localparam logic [7:0] SET_MAR    = 8'h30;
  localparam logic [7:0] LOAD_ADDR  = 8'h31;
  localparam logic [7:0] SET_REG    = 8'h32;
  localparam logic [7:0] SET_MEM    = 8'h33;
  localparam logic [7:0] FETCH_SP   = 8'h40;
  localparam logic [7:0] STACK_REG  = 8'h41;
  localparam logic [7:0] INC_SP     = 8'h42;
  localparam logic [7:0] JUMP       = 8'h50;
  localparam logic [7:0] TMP_JUMP   = 8'h51;
  localparam logic [7:0] STORE_PC   = 8'h52;
  localparam logic [7:0] RET        = 8'h53;
  localparam logic [7:0] MOUT_STORE = 8'h60;
  localparam logic [7:0] ROUT_STORE = 8'h61;
  localparam logic [7:0] IO_WAIT    = 8'h62;
  localparam logic [7:0] HALT       = 8'hFF;

  // Execute-sequence identifiers selected in DECODE
  localparam logic [3:0] SEQ_ALU  = 4'd0;
  localparam logic [3:0] SEQ_MOV  = 4'd1;
  localparam logic [3:0] SEQ_LD   = 4'd2;
  localparam logic [3:0] SEQ_ST   = 4'd3;
  localparam logic [3:0] SEQ_LDI  = 4'd4;
  localparam logic [3:0] SEQ_LDD  = 4'd5;
  localparam logic [3:0] SEQ_PUSH = 4'd6;
  localparam logic [3:0] SEQ_POP  = 4'd7;
  localparam logic [3:0] SEQ_JCC  = 4'd8;
  localparam logic [3:0] SEQ_CALL = 4'd9;
  localparam logic [3:0] SEQ_RET  = 4'd10;
  localparam logic [3:0] SEQ_MOUT = 4'd11;
  localparam logic [3:0] SEQ_ROUT = 4'd12;
  localparam logic [3:0] SEQ_HALT = 4'd13;
  localparam logic [3:0] SEQ_NOP  = 4'd14;

  // Step values: 0 FETCH_PC, 1 FETCH_INST, 2 DECODE, 3.. execute states
  localparam logic [2:0] STEP_EXEC = 3'd3;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);

  logic [2:0]      step;
  logic [2:0]      step_nxt;
  logic [3:0]      seq_sel;
  logic [3:0]      dec_seq;
  logic [2:0]      exec_idx;
  logic [7:0]      state_nxt;
  logic [TO_W-1:0] io_cnt;
  logic            halt_first;
  logic            done;
  logic            leave;
  logic            timeout;

  function automatic logic [3:0] decode_seq(input logic [7:0] instr);
    logic [3:0] s;
    s = SEQ_NOP;
    case (instr[7:6])
      2'b00: s = SEQ_ALU;
      2'b01: s = SEQ_MOV;
      2'b10: begin
        case (instr[5:3])
          3'd0:    s = SEQ_LD;
          3'd1:    s = SEQ_ST;
          3'd2:    s = SEQ_LDI;
          3'd3:    s = SEQ_LDD;
          3'd4:    s = SEQ_PUSH;
          3'd5:    s = SEQ_POP;
          default: s = SEQ_NOP;
        endcase
      end
      default: begin
        case (instr[5:3])
          3'd0:    s = SEQ_JCC;
          3'd1:    s = SEQ_CALL;
          3'd2:    s = SEQ_RET;
          3'd3:    s = SEQ_MOUT;
          3'd4:    s = SEQ_ROUT;
          3'd7:    s = SEQ_HALT;
          default: s = SEQ_NOP;
        endcase
      end
    endcase
    return s;
  endfunction

  function automatic logic [2:0] seq_len(input logic [3:0] s);
    logic [2:0] n;
    case (s)
      SEQ_ALU, SEQ_LDI, SEQ_LDD, SEQ_PUSH, SEQ_JCC:   n = 3'd2;
      SEQ_LD, SEQ_ST, SEQ_POP, SEQ_RET, SEQ_MOUT:     n = 3'd3;
      SEQ_CALL:                                       n = 3'd4;
      default:                                        n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] seq_code(input logic [3:0] s, input logic [2:0] idx);
    logic [7:0] c;
    c = IDLE;
    case (s)
      SEQ_ALU:  c = (idx == 3'd0) ? ALU_EXEC : ALU_OUT;
      SEQ_MOV:  c = MOVE_REG;
      SEQ_LD:   c = (idx == 3'd0) ? FETCH_PC : (idx == 3'd1) ? LOAD_ADDR : SET_REG;
      SEQ_ST:   c = (idx == 3'd0) ? FETCH_PC : (idx == 3'd1) ? LOAD_ADDR : SET_MEM;
      SEQ_LDI:  c = (idx == 3'd0) ? FETCH_PC : SET_REG;
      SEQ_LDD:  c = (idx == 3'd0) ? SET_MAR : SET_REG;
      SEQ_PUSH: c = (idx == 3'd0) ? FETCH_SP : STACK_REG;
      SEQ_POP:  c = (idx == 3'd0) ? INC_SP : (idx == 3'd1) ? FETCH_SP : SET_REG;
      SEQ_JCC:  c = (idx == 3'd0) ? FETCH_PC : JUMP;
      SEQ_CALL: begin
        case (idx)
          3'd0:    c = FETCH_PC;
          3'd1:    c = FETCH_SP;
          3'd2:    c = STORE_PC;
          default: c = TMP_JUMP;
        endcase
      end
      SEQ_RET:  c = (idx == 3'd0) ? INC_SP : (idx == 3'd1) ? FETCH_SP : RET;
      SEQ_MOUT: c = (idx == 3'd0) ? FETCH_PC : (idx == 3'd1) ? LOAD_ADDR : MOUT_STORE;
      SEQ_ROUT: c = ROUT_STORE;
      SEQ_HALT: c = HALT;
      default:  c = IDLE;
    endcase
    return c;
  endfunction

  assign dec_seq  = decode_seq(ir);
  assign exec_idx = step - STEP_EXEC;

  // Next-state logic. The step counter, not the state code, tells fetch apart
  // from a FETCH_PC that appears inside an execute sequence. IO and HALT states
  // are handled by code because they can stall; everything else advances one
  // state per clock. Any instruction end funnels through 'leave', which picks
  // FETCH_PC or IDLE from run_en so run_en only matters at the boundary.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    done      = 1'b0;
    leave     = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (run_en) begin
          state_nxt = FETCH_PC;
          step_nxt  = 3'd0;
        end
      end
      HALT: begin
        done = halt_first;
        if (resume) begin
          state_nxt = FETCH_PC;
          step_nxt  = 3'd0;
        end
      end
      MOUT_STORE, ROUT_STORE: begin
        if (io_ack) begin
          done  = 1'b1;
          leave = 1'b1;
        end else begin
          state_nxt = IO_WAIT;
        end
      end
      IO_WAIT: begin
        if (io_ack) begin
          done  = 1'b1;
          leave = 1'b1;
        end else if (io_cnt == TO_LAST) begin
          done    = 1'b1;
          leave   = 1'b1;
          timeout = 1'b1;
        end
      end
      default: begin
        if (step == 3'd0) begin
          state_nxt = FETCH_INST;
          step_nxt  = 3'd1;
        end else if (step == 3'd1) begin
          state_nxt = DECODE;
          step_nxt  = 3'd2;
        end else if (step == 3'd2) begin
          if (dec_seq == SEQ_NOP) begin
            done  = 1'b1;
            leave = 1'b1;
          end else begin
            state_nxt = seq_code(dec_seq, 3'd0);
            step_nxt  = STEP_EXEC;
          end
        end else if (exec_idx == seq_len(seq_sel) - 3'd1) begin
          done  = 1'b1;
          leave = 1'b1;
        end else begin
          state_nxt = seq_code(seq_sel, exec_idx + 3'd1);
          step_nxt  = step + 3'd1;
        end
      end
    endcase
    if (leave) begin
      state_nxt = run_en ? FETCH_PC : IDLE;
      step_nxt  = 3'd0;
    end
  end

  // State, step and sequence registers. Operands and the selected sequence are
  // captured only in DECODE so they hold steady for the whole instruction.
  // The IO counter runs only while waiting and clears whenever IO_WAIT is left.
  // halt_first marks the first HALT cycle so instr_done pulses once on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      step       <= 3'd0;
      seq_sel    <= SEQ_NOP;
      operand_1  <= 3'd0;
      operand_2  <= 3'd0;
      io_cnt     <= '0;
      io_err     <= 1'b0;
      halt_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      halt_first <= (state_nxt == HALT) && (state != HALT);
      if (state == DECODE) begin
        operand_1 <= ir[5:3];
        operand_2 <= ir[2:0];
        seq_sel   <= dec_seq;
      end
      if ((state == IO_WAIT) && !leave) begin
        io_cnt <= io_cnt + TO_W'(1);
      end else begin
        io_cnt <= '0;
      end
      if (timeout) begin
        io_err <= 1'b1;
      end
    end
  end

  assign instr_done = done;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sequencer
// Self-checking bench for the sequencer. The stimulus thread pushes the state
// code and instr_done value it expects for each cycle onto a scoreboard queue;
// a monitor on the falling edge pops each entry and compares it with the DUT.
// Side outputs (operands, halted, io_err) are checked directly by the thread.
// ---------------------------------------------------------------------------
module tb_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run_en;
  logic       resume;
  logic [7:0] ir;
  logic       io_ack;
  logic [7:0] state;
  logic [2:0] operand_1;
  logic [2:0] operand_2;
  logic       instr_done;
  logic       halted;
  logic       io_err;

  typedef struct packed {
    logic [7:0]  code;
    logic        done;
    logic [15:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   exp_idx;
  int   tests_run;
  int   tests_failed;

  sequencer #(
    .IO_TIMEOUT(4),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run_en(run_en),
    .resume(resume),
    .ir(ir),
    .io_ack(io_ack),
    .state(state),
    .operand_1(operand_1),
    .operand_2(operand_2),
    .instr_done(instr_done),
    .halted(halted),
    .io_err(io_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Load the instruction register ahead of the next DECODE
  task automatic applyStimulus(input logic [7:0] ir_val);
    ir = ir_val;
  endtask

  // Queue the expectation for the current cycle, then move to just after the next edge
  task automatic push_expect(input logic [7:0] code, input logic done);
    exp_t item;
    item.code = code;
    item.done = done;
    item.idx  = 16'(exp_idx);
    sb.push_back(item);
    exp_idx++;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling midway between rising edges
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_item = sb.pop_front();
      checkOutput($sformatf("state#%0d", mon_item.idx), 32'(state), 32'(mon_item.code));
      checkOutput($sformatf("done#%0d", mon_item.idx), 32'(instr_done), 32'(mon_item.done));
    end
  end

  // Main stimulus thread
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_idx      = 0;
    reset_n      = 1'b0;
    run_en       = 1'b1;
    resume       = 1'b0;
    io_ack       = 1'b0;
    ir           = 8'h1A;

    @(posedge clk);
    #1;
    checkOutput("rst_op1", 32'(operand_1), 32'd0);
    checkOutput("rst_op2", 32'(operand_2), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_io_err", 32'(io_err), 32'd0);
    push_expect(8'h00, 1'b0);
    reset_n = 1'b1;
    push_expect(8'h00, 1'b0);

    // ALU r3,r2
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h10, 1'b0);
    checkOutput("alu_op1", 32'(operand_1), 32'd3);
    checkOutput("alu_op2", 32'(operand_2), 32'd2);
    push_expect(8'h11, 1'b1);

    // PUSH r3
    applyStimulus(8'hA3);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h40, 1'b0);
    push_expect(8'h41, 1'b1);

    // POP r3
    applyStimulus(8'hAB);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h42, 1'b0);
    checkOutput("pop_op1", 32'(operand_1), 32'd5);
    checkOutput("pop_op2", 32'(operand_2), 32'd3);
    push_expect(8'h40, 1'b0);
    push_expect(8'h32, 1'b1);

    // ROUT with no ack: times out after four IO_WAIT cycles
    applyStimulus(8'hE0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h61, 1'b0);
    push_expect(8'h62, 1'b0);
    push_expect(8'h62, 1'b0);
    push_expect(8'h62, 1'b0);
    checkOutput("io_err_pre", 32'(io_err), 32'd0);
    push_expect(8'h62, 1'b1);
    checkOutput("io_err_set", 32'(io_err), 32'd1);

    // ROUT acked in the store state itself
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    io_ack = 1'b1;
    push_expect(8'h61, 1'b1);
    io_ack = 1'b0;

    // MOUT acked on the second IO_WAIT cycle
    applyStimulus(8'hD8);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h31, 1'b0);
    push_expect(8'h60, 1'b0);
    push_expect(8'h62, 1'b0);
    io_ack = 1'b1;
    push_expect(8'h62, 1'b1);
    io_ack = 1'b0;
    checkOutput("io_err_sticky", 32'(io_err), 32'd1);

    // Jcc, CALL, RET
    applyStimulus(8'hC0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h50, 1'b1);
    applyStimulus(8'hC8);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h40, 1'b0);
    push_expect(8'h52, 1'b0);
    push_expect(8'h51, 1'b1);
    applyStimulus(8'hD0);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h42, 1'b0);
    push_expect(8'h40, 1'b0);
    push_expect(8'h53, 1'b1);

    // NOP, with a stray resume that must be ignored
    applyStimulus(8'hB0);
    resume = 1'b1;
    push_expect(8'h01, 1'b0);
    resume = 1'b0;
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b1);

    // HALT held for ten cycles, then resumed
    applyStimulus(8'hF8);
    push_expect(8'h01, 1'b0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    checkOutput("halted_on", 32'(halted), 32'd1);
    push_expect(8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push_expect(8'hFF, 1'b0);
    end
    resume = 1'b1;
    push_expect(8'hFF, 1'b0);
    resume = 1'b0;
    checkOutput("halted_off", 32'(halted), 32'd0);
    push_expect(8'h01, 1'b0);

    // LD with run_en dropped mid-sequence: finishes, then parks in IDLE
    applyStimulus(8'h80);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h01, 1'b0);
    run_en = 1'b0;
    push_expect(8'h31, 1'b0);
    push_expect(8'h32, 1'b1);
    push_expect(8'h00, 1'b0);
    push_expect(8'h00, 1'b0);
    run_en = 1'b1;
    push_expect(8'h00, 1'b0);
    push_expect(8'h01, 1'b0);

    // Reset asserted while waiting on IO
    applyStimulus(8'hE0);
    push_expect(8'h02, 1'b0);
    push_expect(8'h03, 1'b0);
    push_expect(8'h61, 1'b0);
    push_expect(8'h62, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_state", 32'(state), 32'h00);
    checkOutput("rst_mid_io_err", 32'(io_err), 32'd0);
    checkOutput("rst_mid_op1", 32'(operand_1), 32'd0);
    checkOutput("rst_mid_op2", 32'(operand_2), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_state", 32'(state), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
